// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage.
// Stalls the pipeline while the multiplier or the restoring divider is busy, then pulses res_valid with HI/LO.
module muldiv_seq #(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic         is_sign,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         cancel,
  output logic         md_stall,
  output logic         res_valid,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] MulLast = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DivLast = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [2*W-1:0] product;
  logic           negQuo;
  logic           negRem;

  // Operand conditioning: magnitudes for the divider, extended operands for the multiplier
  logic           negA;
  logic           negB;
  logic [W-1:0]   absA;
  logic [W-1:0]   absB;
  logic [2*W-1:0] wideA;
  logic [2*W-1:0] wideB;
  logic [2*W-1:0] prodNext;

  always_comb begin
    negA     = is_sign & src_a[W-1];
    negB     = is_sign & src_b[W-1];
    absA     = negA ? (W'(0) - src_a) : src_a;
    absB     = negB ? (W'(0) - src_b) : src_b;
    wideA    = {{W{negA}}, src_a};
    wideB    = {{W{negB}}, src_b};
    prodNext = wideA * wideB;
  end

  // One restoring-division step plus the signed fix-up of its result
  logic [W:0]   trial;
  logic [W:0]   diff;
  logic         fits;
  logic [W-1:0] quoNext;
  logic [W-1:0] remNext;
  logic [W-1:0] quoFix;
  logic [W-1:0] remFix;

  always_comb begin
    trial   = {rem, quo[W-1]};
    diff    = trial - {1'b0, divisor};
    fits    = ~diff[W];
    quoNext = {quo[W-2:0], fits};
    remNext = fits ? diff[W-1:0] : trial[W-1:0];
    quoFix  = negQuo ? (W'(0) - quoNext) : quoNext;
    remFix  = negRem ? (W'(0) - remNext) : remNext;
  end

  // The hazard unit needs the stall in the same cycle the op is seen in E
  assign md_stall = ((state == IDLE) & start & ~cancel) | (state == MUL) | (state == DIV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      divisor   <= '0;
      quo       <= '0;
      rem       <= '0;
      product   <= '0;
      negQuo    <= 1'b0;
      negRem    <= 1'b0;
      res_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      res_valid <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              cnt <= '0;
              if (is_div) begin
                divisor <= absB;
                quo     <= absA;
                rem     <= '0;
                negQuo  <= negA ^ negB;
                negRem  <= negA;
                state   <= DIV;
              end else begin
                product <= prodNext;
                state   <= MUL;
              end
            end
          end
          MUL: begin
            if (cnt == MulLast) begin
              hi        <= product[2*W-1:W];
              lo        <= product[W-1:0];
              res_valid <= 1'b1;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DIV: begin
            quo <= quoNext;
            rem <= remNext;
            if (cnt == DivLast) begin
              hi        <= remFix;
              lo        <= quoFix;
              res_valid <= 1'b1;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DONE: begin
            // The instruction that owned this result leaves E now; a new start is not ours
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO queued at issue, popped on res_valid.
module tb_muldiv_seq;

  localparam int unsigned W       = 32;
  localparam int unsigned MUL_LAT = 2;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_div;
  logic         is_sign;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         cancel;
  logic         md_stall;
  logic         res_valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] lastHi;
  logic [W-1:0] lastLo;

  muldiv_seq #(.W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .is_div(is_div), .is_sign(is_sign),
    .src_a(src_a), .src_b(src_b), .cancel(cancel), .md_stall(md_stall),
    .res_valid(res_valid), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint pa, pb;
    logic [63:0] p;
    logic na, nb;
    logic [31:0] ua, ub, q, m;
    if (!d) begin
      pa = s ? longint'($signed(a)) : longint'({32'd0, a});
      pb = s ? longint'($signed(b)) : longint'({32'd0, b});
      p = 64'(pa * pb);
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else begin
      na = s & a[31];
      nb = s & b[31];
      ua = na ? (32'd0 - a) : a;
      ub = nb ? (32'd0 - b) : b;
      if (ub == 32'd0) begin
        q = 32'hFFFF_FFFF;
        m = ua;
      end else begin
        q = ua / ub;
        m = ua % ub;
      end
      r.lo = (na ^ nb) ? (32'd0 - q) : q;
      r.hi = na ? (32'd0 - m) : m;
    end
    return r;
  endfunction

  // Drives one request (called #1 after a rising edge); push=0 for ops that must never complete
  task automatic issue(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input exp_t e);
    is_div  = d;
    is_sign = s;
    src_a   = a;
    src_b   = b;
    start   = 1'b1;
    if (push) sbQ.push_back(e);
    #1;
  endtask

  // Ends the start pulse, waits (bounded) for res_valid, returns observed and popped expected values
  task automatic wait_result(output int lat, output int stalls, output logic timedOut,
                             output exp_t got, output exp_t want);
    lat = 0; stalls = 0; timedOut = 1'b1; got = '0; want = 'x;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (lat <= 100) begin
      if (res_valid) begin
        timedOut = 1'b0;
        got.hi = hi;
        got.lo = lo;
        if (sbQ.size() > 0) want = sbQ.pop_front();
        break;
      end
      stalls = stalls + (md_stall ? 1 : 0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cancel = 1'b0; is_div = 1'b0; is_sign = 1'b0;
    src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({md_stall, res_valid, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b rv=%b hi=%h lo=%h want all 0", md_stall, res_valid, hi, lo);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    lastHi = '0; lastLo = '0;
  endtask

  task automatic test_mul();
    int lat, stalls; logic to; exp_t got, want;
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001});
    checks++;
    if (md_stall !== 1'b1) begin errors++; $display("FAIL mul_stall_on_start got %b want 1", md_stall); end
    wait_result(lat, stalls, to, got, want);
    checks++;
    if (to || lat != MUL_LAT + 1 || stalls != MUL_LAT) begin
      errors++; $display("FAIL multu_timing got timeout=%b lat=%0d stalls=%0d want lat=%0d stalls=%0d", to, lat, stalls, MUL_LAT + 1, MUL_LAT);
    end
    checks++;
    if (got !== want) begin errors++; $display("FAIL multu_result got %h want %h", got, want); end
    checks++;
    if (md_stall !== 1'b0) begin errors++; $display("FAIL stall_in_done got %b want 0", md_stall); end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL res_valid_one_cycle got %b want 0", res_valid); end

    issue(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b1, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
    wait_result(lat, stalls, to, got, want);
    checks++;
    if (to || got !== want) begin errors++; $display("FAIL mult_signed got timeout=%b %h want %h", to, got, want); end
    lastHi = want.hi; lastLo = want.lo;
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int lat, stalls; logic to; exp_t got, want;
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
    wait_result(lat, stalls, to, got, want);
    checks++;
    if (to || lat != W + 1 || stalls != W) begin
      errors++; $display("FAIL div_timing got timeout=%b lat=%0d stalls=%0d want lat=%0d stalls=%0d", to, lat, stalls, W + 1, W);
    end
    checks++;
    if (got !== want) begin errors++; $display("FAIL div_signed got %h want %h", got, want); end
    @(posedge clk); #1;

    issue(1'b1, 1'b0, 32'd100, 32'd0, 1'b1, '{hi: 32'd100, lo: 32'hFFFF_FFFF});
    wait_result(lat, stalls, to, got, want);
    checks++;
    if (to || lat != W + 1 || got !== want) begin
      errors++; $display("FAIL divu_by_zero got timeout=%b lat=%0d %h want %h", to, lat, got, want);
    end
    @(posedge clk); #1;

    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, '{hi: 32'd0, lo: 32'h8000_0000});
    wait_result(lat, stalls, to, got, want);
    checks++;
    if (to || got !== want) begin errors++; $display("FAIL div_overflow got timeout=%b %h want %h", to, got, want); end
    lastHi = want.hi; lastLo = want.lo;
    @(posedge clk); #1;
  endtask

  task automatic test_cancel();
    int lat, stalls, pulses; logic to; exp_t got, want;
    // Start and cancel in the same IDLE cycle never begins an operation
    cancel = 1'b1;
    issue(1'b0, 1'b0, 32'd5, 32'd6, 1'b0, '0);
    checks++;
    if (md_stall !== 1'b0) begin errors++; $display("FAIL cancel_masks_start got %b want 0", md_stall); end
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (md_stall !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL cancel_idle_stays got stall=%b rv=%b want 0 0", md_stall, res_valid);
    end

    issue(1'b1, 1'b1, 32'd1000, 32'd7, 1'b0, '0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++;
    if (md_stall !== 1'b0 || res_valid !== 1'b0 || hi !== lastHi || lo !== lastLo) begin
      errors++; $display("FAIL cancel_div got stall=%b rv=%b hi=%h lo=%h want 0 0 %h %h", md_stall, res_valid, hi, lo, lastHi, lastLo);
    end
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; pulses = pulses + (res_valid ? 1 : 0); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL cancel_no_result got %0d pulses want 0", pulses); end

    issue(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd7, 1'b1, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFDD});
    wait_result(lat, stalls, to, got, want);
    checks++;
    if (to || lat != MUL_LAT + 1 || got !== want) begin
      errors++; $display("FAIL mult_after_cancel got timeout=%b lat=%0d %h want %h", to, lat, got, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 32'd12345, 32'd17, 1'b0, '0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({md_stall, res_valid, hi, lo} !== '0) begin
      errors++; $display("FAIL async_reset got stall=%b rv=%b hi=%h lo=%h want all 0", md_stall, res_valid, hi, lo);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    lastHi = '0; lastLo = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_done_ignore();
    int lat, stalls, busy; logic to; exp_t got, want;
    issue(1'b0, 1'b0, 32'd3, 32'd4, 1'b1, '{hi: 32'd0, lo: 32'd12});
    wait_result(lat, stalls, to, got, want);
    checks++;
    if (to || got !== want) begin errors++; $display("FAIL done_first_op got timeout=%b %h want %h", to, got, want); end
    issue(1'b1, 1'b0, 32'd99, 32'd9, 1'b0, '0);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    busy = 0;
    repeat (40) begin
      busy = busy + ((res_valid || md_stall) ? 1 : 0);
      @(posedge clk); #1;
    end
    checks++;
    if (busy != 0 || hi !== want.hi || lo !== want.lo) begin
      errors++; $display("FAIL start_in_done_ignored got busy=%0d hi=%h lo=%h want 0 %h %h", busy, hi, lo, want.hi, want.lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat, stalls; logic to; exp_t got, want;
    logic d, s; logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      d = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i == 3) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
      issue(d, s, a, b, 1'b1, model(d, s, a, b));
      wait_result(lat, stalls, to, got, want);
      checks++;
      if (to || lat != (d ? W + 1 : MUL_LAT + 1) || got !== want) begin
        errors++; $display("FAIL b2b_op%0d div=%b sign=%b a=%h b=%h got timeout=%b lat=%0d %h want %h", i, d, s, a, b, to, lat, got, want);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sbQ.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d left want 0", sbQ.size()); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_cancel();
    test_reset_mid();
    test_done_ignore();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
